// File: rtl/cr_pkg.sv
// cr_pkg: shared state encoding, widths and the round-robin pick helper
// for the cognitive-radio channel scheduler.
package cr_pkg;

    localparam int N_CH_DEF = 3;
    localparam int N_SU_DEF = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SENSE  = 2'd1;
    localparam logic [1:0] ST_ALLOC  = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SENSE  = ST_SENSE,
        ALLOC  = ST_ALLOC,
        STREAM = ST_STREAM
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_width(N_CH_DEF);
    typedef logic [CH_W-1:0] ch_idx_t;

    // The helper works on the largest supported requester count (8);
    // callers zero-extend their request vector.
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !r.found && req[idx]) begin
                r.found = 1'b1;
                r.idx   = 3'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cr_channel_scheduler_rr.sv
// cr_rr_arbiter: one round-robin pick over the SU requests, starting at ptr_i.
// Outputs the request vector with the winner removed and the pointer after
// the winner, so several instances can be chained one per channel.
module cr_rr_arbiter
    import cr_pkg::*;
#(
    parameter  int N_SU = 4,
    localparam int SUW  = (N_SU > 1) ? $clog2(N_SU) : 1
) (
    input  logic [N_SU-1:0] req_i,
    input  logic [SUW-1:0]  ptr_i,
    input  logic            en_i,
    output logic            found_o,
    output logic [SUW-1:0]  idx_o,
    output logic [N_SU-1:0] req_nxt_o,
    output logic [SUW-1:0]  ptr_nxt_o
);

    rr_pick_t   pick;
    logic [7:0] req_ext;

    // Pick the first requester at or after the pointer, wrapping at N_SU.
    always_comb begin
        req_ext            = '0;
        req_ext[N_SU-1:0]  = req_i;
        pick               = rr_pick(req_ext, 3'(ptr_i), N_SU);
        found_o            = en_i && pick.found;
        idx_o              = SUW'(pick.idx);
        req_nxt_o          = req_i;
        ptr_nxt_o          = ptr_i;
        if (found_o) begin
            req_nxt_o[idx_o] = 1'b0;
            ptr_nxt_o        = (idx_o == SUW'(N_SU - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/cr_channel_scheduler.sv
// cr_channel_scheduler: frame-level sense / allocate / stream controller for
// the cognitive-radio receive path. Owns every d-line transition.
//
// state  | meaning
// IDLE   | single cycle after reset, nothing owned, all d-lines licensed
// SENSE  | OR pu_active into occ over SENSE_CYC cycles, grants held
// ALLOC  | evict/renew holders, lend free channels round-robin
// STREAM | FRAME_LEN bit-times; a returning PU evicts its borrower
module cr_channel_scheduler
    import cr_pkg::*;
#(
    parameter  int N_CH      = N_CH_DEF,
    parameter  int N_SU      = N_SU_DEF,
    parameter  int FRAME_LEN = 100,
    parameter  int SENSE_CYC = 4,
    localparam int CHW       = ch_width(N_CH),
    localparam int SUW       = (N_SU > 1) ? $clog2(N_SU) : 1,
    localparam int SCW       = (SENSE_CYC > 1) ? $clog2(SENSE_CYC) : 1,
    localparam int BIW       = $clog2(FRAME_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     pu_active,
    input  logic [N_SU-1:0]     su_req,
    input  logic [N_SU-1:0]     su_release,
    output logic [N_SU-1:0]     su_grant,
    output logic [N_SU*CHW-1:0] su_ch,
    output logic [N_SU-1:0]     su_evict,
    output logic [N_CH-1:0]     d_sel,
    output logic                frame_start,
    output logic [BIW-1:0]      bit_idx,
    output logic                busy
);

    state_t          state_q, state_d;
    logic [SCW-1:0]  sense_cnt_q, sense_cnt_d;
    logic [BIW-1:0]  bit_idx_q, bit_idx_d;
    logic [N_CH-1:0] occ_q, occ_d;
    logic [N_CH-1:0] d_sel_q, d_sel_d;
    logic [SUW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_SU-1:0] grant_q, grant_d;
    logic [N_SU-1:0] evict_q, evict_d;
    logic [CHW-1:0]  ch_q [N_SU];
    logic [CHW-1:0]  ch_d [N_SU];

    logic [N_SU-1:0] keep;
    logic [N_CH-1:0] owned;
    logic [N_CH-1:0] ch_free;
    logic [N_SU-1:0] alloc_req;
    logic [N_CH-1:0] pick_found;
    logic [SUW-1:0]  pick_idx [N_CH];
    logic [SUW-1:0]  alloc_ptr;

    // Channels still owned after ALLOC renewal; only the rest can be lent.
    always_comb begin
        keep  = grant_q & ~su_release;
        owned = '0;
        for (int s = 0; s < N_SU; s++) begin
            if (keep[s] && !occ_q[ch_q[s]]) owned[ch_q[s]] = 1'b1;
        end
        ch_free = '0;
        if (state_q == ALLOC) ch_free = ~occ_q & ~owned;
        alloc_req = su_req & ~grant_q;
    end

    // One arbiter per channel, chained so lower channels pick first and
    // each later pick starts after the previous winner.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [N_SU-1:0] req_in, req_out;
        logic [SUW-1:0]  ptr_in, ptr_out, idx;
        logic            found;
        if (c == 0) begin : g_head
            assign req_in = alloc_req;
            assign ptr_in = rr_ptr_q;
        end else begin : g_link
            assign req_in = g_ch[c-1].req_out;
            assign ptr_in = g_ch[c-1].ptr_out;
        end
        cr_rr_arbiter #(.N_SU(N_SU)) u_arb (
            .req_i     (req_in),
            .ptr_i     (ptr_in),
            .en_i      (ch_free[c]),
            .found_o   (found),
            .idx_o     (idx),
            .req_nxt_o (req_out),
            .ptr_nxt_o (ptr_out)
        );
        assign pick_found[c] = found;
        assign pick_idx[c]   = idx;
    end
    assign alloc_ptr = g_ch[N_CH-1].ptr_out;

    // Next-state, grant bookkeeping and d-line derivation.
    always_comb begin
        state_d     = state_q;
        sense_cnt_d = sense_cnt_q;
        bit_idx_d   = '0;
        occ_d       = occ_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        ch_d        = ch_q;
        evict_d     = '0;
        case (state_q)
            IDLE: begin
                state_d     = SENSE;
                sense_cnt_d = SCW'(SENSE_CYC - 1);
                occ_d       = '0;
            end
            SENSE: begin
                occ_d   = occ_q | pu_active;
                grant_d = grant_q & ~su_release;
                if (sense_cnt_q == '0) state_d = ALLOC;
                else                   sense_cnt_d = sense_cnt_q - 1'b1;
            end
            ALLOC: begin
                for (int s = 0; s < N_SU; s++) begin
                    if (grant_q[s] && (su_release[s] || occ_q[ch_q[s]])) begin
                        grant_d[s] = 1'b0;
                        evict_d[s] = !su_release[s];
                    end
                end
                for (int c = 0; c < N_CH; c++) begin
                    if (pick_found[c]) begin
                        grant_d[pick_idx[c]] = 1'b1;
                        ch_d[pick_idx[c]]    = CHW'(c);
                    end
                end
                rr_ptr_d = alloc_ptr;
                state_d  = STREAM;
            end
            STREAM: begin
                // A release on the same cycle as a PU return wins: no evict.
                for (int s = 0; s < N_SU; s++) begin
                    if (grant_q[s]) begin
                        if (su_release[s]) begin
                            grant_d[s] = 1'b0;
                        end else if (pu_active[ch_q[s]]) begin
                            grant_d[s] = 1'b0;
                            evict_d[s] = 1'b1;
                        end
                    end
                end
                if (bit_idx_q == BIW'(FRAME_LEN - 1)) begin
                    state_d     = SENSE;
                    sense_cnt_d = SCW'(SENSE_CYC - 1);
                    occ_d       = '0;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        d_sel_d = '1;
        for (int s = 0; s < N_SU; s++) begin
            if (grant_d[s]) d_sel_d[ch_d[s]] = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sense_cnt_q <= '0;
            bit_idx_q   <= '0;
            occ_q       <= '0;
            d_sel_q     <= '1;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            evict_q     <= '0;
            for (int s = 0; s < N_SU; s++) ch_q[s] <= '0;
        end else begin
            state_q     <= state_d;
            sense_cnt_q <= sense_cnt_d;
            bit_idx_q   <= bit_idx_d;
            occ_q       <= occ_d;
            d_sel_q     <= d_sel_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            evict_q     <= evict_d;
            ch_q        <= ch_d;
        end
    end

    for (genvar s = 0; s < N_SU; s++) begin : g_su_ch
        assign su_ch[s*CHW +: CHW] = ch_q[s];
    end

    assign su_grant    = grant_q;
    assign su_evict    = evict_q;
    assign d_sel       = d_sel_q;
    assign bit_idx     = bit_idx_q;
    assign busy        = (state_q != IDLE);
    assign frame_start = (state_q == STREAM) && (bit_idx_q == '0);

endmodule

// File: tb/tb_cr_channel_scheduler.sv
// Testbench for cr_channel_scheduler: directed scenarios plus randomized
// traffic, every cycle compared against a frame-schedule reference model.
module tb_cr_channel_scheduler;

    localparam int N_CH      = 3;
    localparam int N_SU      = 4;
    localparam int FRAME_LEN = 100;
    localparam int SENSE_CYC = 4;
    localparam int CHW       = 2;
    localparam int BIW       = 7;
    localparam int P         = SENSE_CYC + 1 + FRAME_LEN;
    localparam int PH_IDLE = 0, PH_SENSE = 1, PH_ALLOC = 2, PH_STREAM = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_CH-1:0]     pu_active;
    logic [N_SU-1:0]     su_req, su_release;
    logic [N_SU-1:0]     su_grant, su_evict;
    logic [N_SU*CHW-1:0] su_ch;
    logic [N_CH-1:0]     d_sel;
    logic                frame_start, busy;
    logic [BIW-1:0]      bit_idx;

    always #5 clk = ~clk;

    cr_channel_scheduler #(.N_CH(N_CH), .N_SU(N_SU), .FRAME_LEN(FRAME_LEN),
                           .SENSE_CYC(SENSE_CYC)) dut (
        .clk(clk), .rst(rst), .pu_active(pu_active), .su_req(su_req),
        .su_release(su_release), .su_grant(su_grant), .su_ch(su_ch),
        .su_evict(su_evict), .d_sel(d_sel), .frame_start(frame_start),
        .bit_idx(bit_idx), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: the schedule is a pure function of cycles since reset;
    // ownership is tracked as channel-per-SU.
    int              m_k = 0;
    bit [N_SU-1:0]   m_grant = '0;
    bit [N_SU-1:0]   m_evict = '0;
    int              m_ch [N_SU];
    bit [N_CH-1:0]   m_occ = '0;
    int              m_ptr = 0;

    function automatic int phase_of(input int k);
        int m;
        if (k == 0) return PH_IDLE;
        m = (k - 1) % P;
        if (m < SENSE_CYC)  return PH_SENSE;
        if (m == SENSE_CYC) return PH_ALLOC;
        return PH_STREAM;
    endfunction

    function automatic int bit_of(input int k);
        if (phase_of(k) != PH_STREAM) return 0;
        return (k - 1) % P - SENSE_CYC - 1;
    endfunction

    task automatic model_edge(input logic [N_CH-1:0] pu, input logic [N_SU-1:0] req,
                              input logic [N_SU-1:0] rel, input logic r);
        int            ph;
        int            s;
        bit [N_SU-1:0] was;
        bit [N_CH-1:0] taken;
        if (r) begin
            m_k = 0; m_grant = '0; m_evict = '0; m_occ = '0; m_ptr = 0;
            for (int i = 0; i < N_SU; i++) m_ch[i] = 0;
            return;
        end
        ph      = phase_of(m_k);
        m_evict = '0;
        was     = m_grant;
        if (ph == PH_SENSE) m_occ |= pu;
        if (ph != PH_IDLE) begin
            for (int i = 0; i < N_SU; i++) begin
                if (was[i] && rel[i]) m_grant[i] = 1'b0;
                else if (was[i] && ((ph == PH_STREAM && pu[m_ch[i]]) ||
                                    (ph == PH_ALLOC && m_occ[m_ch[i]]))) begin
                    m_grant[i] = 1'b0;
                    m_evict[i] = 1'b1;
                end
            end
        end
        if (ph == PH_ALLOC) begin
            taken = '0;
            for (int i = 0; i < N_SU; i++) if (m_grant[i]) taken[m_ch[i]] = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (!m_occ[c] && !taken[c]) begin
                    for (int j = 0; j < N_SU; j++) begin
                        s = (m_ptr + j) % N_SU;
                        if (req[s] && !was[s] && !m_grant[s]) begin
                            m_grant[s] = 1'b1;
                            m_ch[s]    = c;
                            m_ptr      = (s + 1) % N_SU;
                            break;
                        end
                    end
                end
            end
        end
        m_k++;
        if (phase_of(m_k) == PH_SENSE && (m_k - 1) % P == 0) m_occ = '0;
    endtask

    task automatic compare_all();
        logic [N_CH-1:0] exp_d;
        exp_d = '1;
        for (int s = 0; s < N_SU; s++) if (m_grant[s]) exp_d[m_ch[s]] = 1'b0;
        chk("su_grant", 32'(su_grant), 32'(m_grant));
        chk("su_evict", 32'(su_evict), 32'(m_evict));
        chk("d_sel", 32'(d_sel), 32'(exp_d));
        chk("bit_idx", 32'(bit_idx), 32'(bit_of(m_k)));
        chk("busy", 32'(busy), 32'(m_k != 0));
        chk("frame_start", 32'(frame_start),
            32'(phase_of(m_k) == PH_STREAM && bit_of(m_k) == 0));
        for (int s = 0; s < N_SU; s++)
            if (m_grant[s]) chk("su_ch", 32'(su_ch[s*CHW +: CHW]), 32'(m_ch[s]));
    endtask

    task automatic step(input logic [N_CH-1:0] pu, input logic [N_SU-1:0] req,
                        input logic [N_SU-1:0] rel, input logic r);
        pu_active  = pu;
        su_req     = req;
        su_release = rel;
        rst        = r;
        model_edge(pu, req, rel, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_to(input int k_target, input logic [N_CH-1:0] pu,
                          input logic [N_SU-1:0] req);
        for (int i = 0; i < 20000 && m_k < k_target; i++) step(pu, req, '0, 1'b0);
    endtask

    logic [N_SU-1:0] rot_g [3];
    int              rot_own [3][N_CH];
    logic [N_CH-1:0] pu_r;
    logic [N_SU-1:0] req_r, rel_r;
    logic            rst_r;

    initial begin
        rot_g   = '{4'b0111, 4'b1011, 4'b1101};
        rot_own = '{'{0, 1, 2}, '{3, 0, 1}, '{2, 3, 0}};

        // Reset state.
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        chk("rst_grant", 32'(su_grant), 32'h0);
        chk("rst_su_ch", 32'(su_ch), 32'h0);
        chk("rst_d_sel", 32'(d_sel), 32'h7);
        chk("rst_busy", 32'(busy), 32'h0);

        // First allocation with channel 1 occupied.
        run_to(6, 3'b010, 4'b0011);
        chk("t1_grant", 32'(su_grant), 32'h3);
        chk("t1_ch0", 32'(su_ch[0 +: CHW]), 32'd0);
        chk("t1_ch1", 32'(su_ch[CHW +: CHW]), 32'd2);
        chk("t1_d_sel", 32'(d_sel), 32'h2);
        chk("t1_frame_start", 32'(frame_start), 32'h1);
        chk("t1_bit_idx", 32'(bit_idx), 32'd0);

        // PU returns on channel 2 at bit 40.
        run_to(46, 3'b010, 4'b0011);
        step(3'b110, 4'b0011, '0, 1'b0);
        chk("t2_d_sel", 32'(d_sel), 32'h6);
        chk("t2_grant", 32'(su_grant), 32'h1);
        chk("t2_evict", 32'(su_evict), 32'h2);
        chk("t2_bit_idx", 32'(bit_idx), 32'd41);
        step(3'b110, 4'b0011, '0, 1'b0);
        chk("t2_evict_pulse", 32'(su_evict), 32'h0);

        // Release and PU return on the same channel.
        step(3'b111, 4'b0011, 4'b0001, 1'b0);
        chk("t5_evict", 32'(su_evict), 32'h0);
        chk("t5_grant", 32'(su_grant), 32'h0);
        chk("t5_d_sel", 32'(d_sel), 32'h7);

        // Round-robin rotation over three frames.
        step('0, '0, '0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            run_to(6 + f * P, 3'b000, 4'b1111);
            chk("rot_grant", 32'(su_grant), 32'(rot_g[f]));
            for (int c = 0; c < N_CH; c++)
                chk("rot_ch", 32'(su_ch[rot_own[f][c]*CHW +: CHW]), 32'(c));
            run_to(16 + f * P, 3'b000, 4'b1111);
            step(3'b000, 4'b1111, rot_g[f], 1'b0);
        end

        // Renewal across frame boundaries.
        step('0, '0, '0, 1'b1);
        run_to(6, 3'b000, 4'b0001);
        for (int i = 0; i < 2 * P; i++) begin
            step(3'b000, 4'b0001, '0, 1'b0);
            chk("renew_grant", 32'(su_grant[0]), 32'h1);
            chk("renew_ch", 32'(su_ch[0 +: CHW]), 32'd0);
        end

        // Reset in the middle of a frame with two grants held.
        step('0, '0, '0, 1'b1);
        run_to(6 + 57, 3'b000, 4'b0011);
        chk("t6_pre_grant", 32'(su_grant), 32'h3);
        step(3'b000, 4'b0011, '0, 1'b1);
        chk("t6_grant", 32'(su_grant), 32'h0);
        chk("t6_d_sel", 32'(d_sel), 32'h7);
        chk("t6_bit_idx", 32'(bit_idx), 32'd0);
        chk("t6_busy", 32'(busy), 32'h0);
        run_to(6, 3'b000, 4'b0011);
        chk("t6_regrant", 32'(su_grant), 32'h3);

        // Randomized traffic.
        pu_r  = '0;
        req_r = '0;
        for (int i = 0; i < 15 * P; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (pu_r[c]) begin if ($urandom_range(0, 15) == 0) pu_r[c] = 1'b0; end
                else if ($urandom_range(0, 127) == 0) pu_r[c] = 1'b1;
            end
            rel_r = '0;
            for (int s = 0; s < N_SU; s++) begin
                if ($urandom_range(0, 31) == 0) req_r[s] = ~req_r[s];
                if ($urandom_range(0, 47) == 0) rel_r[s] = 1'b1;
            end
            rst_r = (i == 800) || ($urandom_range(0, 1499) == 0);
            step(pu_r, req_r, rel_r, rst_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
